// File: rtl/math_unit_seq_pkg.sv
// Shared opcodes and FSM state encoding for the sequential math unit.
package math_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_SHL = 2'd2;
  localparam logic [1:0] OP_SHR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/math_unit_seq_addsub.sv
// Combinational WIDTH-bit adder/subtractor; carry is borrow on SUB, ovf is signed overflow.
module math_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign carry = sub ? ~full[WIDTH] : full[WIDTH];
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/math_unit_seq.sv
// ADD/SUB in 1 cycle, shifts iterate one bit per cycle (k cycles); valid/ready on both sides.
// Result is held in DONE until out_ready; a new op may be accepted on the retiring edge.
module math_unit_seq
  import math_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ARITH_SHR = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           y,
  output logic                       carry,
  output logic                       ovf,
  output logic                       zero
);

  localparam int SW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    cnt;
  logic             shr_r;
  logic             accept;
  logic             is_shift;
  logic [WIDTH-1:0] sum_w;
  logic             carry_w;
  logic             ovf_w;
  logic [WIDTH:0]   step_a;
  logic [WIDTH:0]   step_acc;

  // One-bit shift; MSB of the result is the bit shifted out.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] v, input logic shr);
    logic fill;
    fill = (ARITH_SHR != 0) ? v[WIDTH-1] : 1'b0;
    if (shr) step = {v[0], fill, v[WIDTH-1:1]};
    else     step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
  endfunction

  assign is_shift = op[1];
  assign accept   = in_valid && in_ready;
  assign step_a   = step(a, op == OP_SHR);
  assign step_acc = step(acc, shr_r);

  math_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (a),
    .b     (b),
    .sub   (op == OP_SUB),
    .sum   (sum_w),
    .carry (carry_w),
    .ovf   (ovf_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE:  in_ready = 1'b1;
      ST_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        if (out_ready && !in_valid) state_nxt = ST_IDLE;
      end
      ST_SHIFT: if (cnt == SW'(1)) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (accept) state_nxt = (!is_shift || shamt <= SW'(1)) ? ST_DONE : ST_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      shr_r <= 1'b0;
      y     <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      if (!is_shift) begin
        y     <= sum_w;
        carry <= carry_w;
        ovf   <= ovf_w;
        zero  <= (sum_w == '0);
      end else if (shamt == '0) begin
        y     <= a;
        carry <= 1'b0;
        ovf   <= 1'b0;
        zero  <= (a == '0);
      end else if (shamt == SW'(1)) begin
        y     <= step_a[WIDTH-1:0];
        carry <= step_a[WIDTH];
        ovf   <= 1'b0;
        zero  <= (step_a[WIDTH-1:0] == '0);
      end else begin
        acc   <= step_a[WIDTH-1:0];
        cnt   <= shamt - SW'(1);
        shr_r <= (op == OP_SHR);
      end
    end else if (state == ST_SHIFT) begin
      acc <= step_acc[WIDTH-1:0];
      cnt <= cnt - SW'(1);
      // Final iteration publishes the result in the same edge it is computed.
      if (cnt == SW'(1)) begin
        y     <= step_acc[WIDTH-1:0];
        carry <= step_acc[WIDTH];
        ovf   <= 1'b0;
        zero  <= (step_acc[WIDTH-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_math_unit_seq.sv
// Directed checks of math_unit_seq: arithmetic SHR instance plus a logical SHR instance on shared inputs.
module tb_math_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] op;
  logic [7:0] a, b;
  logic [2:0] shamt;

  logic       in_ready, out_valid, carry, ovf, zero;
  logic [7:0] y;
  logic       in_ready_l, out_valid_l, carry_l, ovf_l, zero_l;
  logic [7:0] y_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  math_unit_seq #(.WIDTH(8), .ARITH_SHR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .ovf(ovf), .zero(zero)
  );

  math_unit_seq #(.WIDTH(8), .ARITH_SHR(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l), .op(op),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid_l), .out_ready(out_ready),
    .y(y_l), .carry(carry_l), .ovf(ovf_l), .zero(zero_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'd0; a = '0; b = '0; shamt = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_y", y, 0);
    chk("rst_flags", {carry, ovf, zero}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADD FF+01
    in_valid = 1'b1; op = 2'd0; a = 8'hFF; b = 8'h01;
    tick();
    chk("add1_valid", out_valid, 1);
    chk("add1_y", y, 8'h00);
    chk("add1_flags", {carry, ovf, zero}, 3'b101);

    // ADD 7F+01, accepted back-to-back from DONE
    a = 8'h7F; b = 8'h01;
    tick();
    chk("add2_valid", out_valid, 1);
    chk("add2_y", y, 8'h80);
    chk("add2_flags", {carry, ovf, zero}, 3'b010);

    // SUB 03-05
    op = 2'd1; a = 8'h03; b = 8'h05;
    tick();
    chk("sub_y", y, 8'hFE);
    chk("sub_flags", {carry, ovf, zero}, 3'b100);

    // SHR 90 by 3; operands changed after accept must not matter
    op = 2'd3; a = 8'h90; shamt = 3'd3;
    tick();
    in_valid = 1'b0; a = 8'h00; shamt = 3'd7; op = 2'd0;
    chk("shr_e1_valid", out_valid, 0);
    chk("shr_e1_in_ready", in_ready, 0);
    tick();
    chk("shr_e2_valid", out_valid, 0);
    tick();
    chk("shr_e3_valid", out_valid, 1);
    chk("shr_arith_y", y, 8'hF2);
    chk("shr_arith_flags", {carry, ovf, zero}, 3'b000);
    chk("shr_logic_y", y_l, 8'h12);
    chk("shr_logic_flags", {carry_l, ovf_l, zero_l}, 3'b000);
    chk("shr_logic_hs", {out_valid_l, in_ready_l}, 2'b11);

    // SHL 81 by 1: single-cycle
    in_valid = 1'b1; op = 2'd2; a = 8'h81; shamt = 3'd1;
    tick();
    in_valid = 1'b0;
    chk("shl1_valid", out_valid, 1);
    chk("shl1_y", y, 8'h02);
    chk("shl1_carry", carry, 1);
    tick();
    chk("retire_idle_valid", out_valid, 0);
    chk("retire_hold_y", y, 8'h02);

    // Backpressure: ADD 10+20 held while a SUB waits
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd0; a = 8'h10; b = 8'h20;
    tick();
    op = 2'd1; a = 8'h09; b = 8'h04;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y", y, 8'h30);
      chk("bp_flags", {carry, ovf, zero}, 3'b000);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_valid", out_valid, 1);
    chk("bp_new_y", y, 8'h05);
    chk("bp_new_flags", {carry, ovf, zero}, 3'b000);
    tick();
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_hold_y", y, 8'h05);

    // SHL 01 by 6, reset on the third SHIFT cycle
    in_valid = 1'b1; op = 2'd2; a = 8'h01; shamt = 3'd6;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_y", y, 0);
    chk("midrst_flags", {carry, ovf, zero}, 0);
    chk("midrst_hs", {out_valid, in_ready}, 2'b01);
    tick();
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) seen_valid++;
    end
    chk("postrst_no_valid", seen_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
